layer_scan_scheduler: RTL and testbench

//  Time-multiplexes the LED cube layers. For each layer it:
//   - requests that layer's column data from the shift loader (req/done handshake),
//   - pulses the column latch,
//   - drives a one-hot layer enable for a fixed hold time.
//  It then advances to the next layer, wrapping at NUM_LAYERS, and flags each

---
 rtl/layer_scan_scheduler.sv | 135 +++++++++++++
 tb/tb_layer_scan_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_scan_scheduler.sv
// Layer scan scheduler for the LED cube: loads, latches and lights each layer in turn,
// wrapping at NUM_LAYERS and pulsing frame_done_o once per completed frame.
module layer_scan_scheduler #(
  parameter int NUM_LAYERS   = 8,
  parameter int HOLD_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  output logic                  load_req_o,
  output logic [2:0]            load_layer_o,
  input  logic                  load_done_i,
  output logic                  latch_o,
  output logic [NUM_LAYERS-1:0] layer_out_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load_req_q, load_req_d;
  logic                    latch_q, latch_d;
  logic [NUM_LAYERS-1:0]   layer_out_q, layer_out_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;

  // Every output is computed here from the next state so that it can be
  // registered alongside the state itself.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    load_req_d   = 1'b0;
    latch_d      = 1'b0;
    layer_out_d  = '0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d    = LOAD;
          load_req_d = 1'b1;
        end
      end

      LOAD: begin
        cnt_d      = '0;
        load_req_d = 1'b1;
        if (load_done_i) begin
          state_d    = BLANK;
          load_req_d = 1'b0;
          latch_d    = 1'b1;
        end
      end

      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = HOLD;
          cnt_d       = '0;
          layer_out_d = NUM_LAYERS'(1) << idx_q;
        end
      end

      HOLD: begin
        layer_out_d = NUM_LAYERS'(1) << idx_q;
        if (cnt_q == HOLD_LAST) begin
          // The index advances even when we fall back to IDLE, so a later
          // re-enable resumes at the following layer.
          cnt_d        = '0;
          layer_out_d  = '0;
          frame_done_d = (idx_q == LAST_LAYER);
          idx_d        = (idx_q == LAST_LAYER) ? 3'd0 : idx_q + 3'd1;
          if (enable_i) begin
            state_d    = LOAD;
            load_req_d = 1'b1;
          end else begin
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      load_req_q   <= 1'b0;
      latch_q      <= 1'b0;
      layer_out_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      load_req_q   <= load_req_d;
      latch_q      <= latch_d;
      layer_out_q  <= layer_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign load_req_o   = load_req_q;
  assign load_layer_o = idx_q;
  assign latch_o      = latch_q;
  assign layer_out_o  = layer_out_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_layer_scan_scheduler.sv
// Bench for layer_scan_scheduler: directed scenarios plus a random enable/load_done run,
// all compared every cycle against a position-in-layer-period reference model.
module tb_layer_scan_scheduler;

  localparam int N = 8;
  localparam int H = 4;
  localparam int B = 2;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         load_done;
  logic         load_req;
  logic [2:0]   load_layer;
  logic         latch;
  logic [N-1:0] layer_out;
  logic         frame_done;
  logic         busy;

  int nAsserts = 0;
  int nFail    = 0;

  // Model: mPos=-1 idle, 0 loading, 1..B blanking, B+1..B+H lit.
  int mPos   = -1;
  int mLayer = 0;
  bit mFrame = 1'b0;

  layer_scan_scheduler #(
    .NUM_LAYERS  (N),
    .HOLD_CYCLES (H),
    .BLANK_CYCLES(B),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .load_req_o  (load_req),
    .load_layer_o(load_layer),
    .load_done_i (load_done),
    .latch_o     (latch),
    .layer_out_o (layer_out),
    .frame_done_o(frame_done),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic done);
    enable    = en;
    load_done = done;
  endtask

  // Advance the model across one clock edge using the inputs presented to the DUT.
  task automatic modelStep();
    mFrame = 1'b0;
    if (!rst_n) begin
      mPos   = -1;
      mLayer = 0;
    end else if (mPos == -1) begin
      if (enable) mPos = 0;
    end else if (mPos == 0) begin
      if (load_done) mPos = 1;
    end else if (mPos < B + H) begin
      mPos++;
    end else begin
      mFrame = (mLayer == N - 1);
      mLayer = (mLayer + 1) % N;
      mPos   = enable ? 0 : -1;
    end
  endtask

  task automatic checkOutput();
    checkEq("load_req",   load_req,   mPos == 0);
    checkEq("load_layer", load_layer, mLayer);
    checkEq("latch",      latch,      mPos == 1);
    checkEq("layer_out",  layer_out,  (mPos > B) ? (32'd1 << mLayer) : 32'd0);
    checkEq("frame_done", frame_done, mFrame);
    checkEq("busy",       busy,       mPos != -1);
    checkEq("onehot0",    $onehot0(layer_out), 1);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int n;
    int frames;
    int latches;
    int lit;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkEq("reset_busy",      busy,      0);
    checkEq("reset_layer_out", layer_out, 0);
    rst_n = 1'b1;
    tick();
    checkEq("idle_no_enable",  busy,      0);

    $display("[TB] Scenario 1: free-running scan");
    applyStimulus(1'b1, 1'b1);
    frames  = 0;
    latches = 0;
    for (int t = 1; t <= 120; t++) begin
      tick();
      if (frame_done) frames++;
      if (latch) latches++;
      if (t == 4)  checkEq("s1_l0_first_lit", layer_out, 8'h01);
      if (t == 7)  checkEq("s1_l0_last_lit",  layer_out, 8'h01);
      if (t == 8)  checkEq("s1_l1_load",      {load_req, layer_out, 5'd0, load_layer}, {1'b1, 8'h00, 8'h01});
      if (t == 11) checkEq("s1_l1_lit",       layer_out, 8'h02);
    end
    checkEq("s1_frame_pulses", frames,  2);
    checkEq("s1_latch_pulses", latches, 17);

    $display("[TB] Scenario 2: stalled load of layer 3");
    n = 0;
    while (!(mLayer == 2 && mPos >= 1) && n < 100) begin tick(); n++; end
    checkEq("s2_reach_l2", n < 100, 1);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!(mLayer == 3 && mPos == 0) && n < 100) begin tick(); n++; end
    checkEq("s2_reach_l3_load", n < 100, 1);
    for (int t = 0; t < 10; t++) begin
      tick();
      checkEq("s2_req_held",   load_req,   1);
      checkEq("s2_layer_held", load_layer, 3);
      checkEq("s2_dark",       layer_out,  0);
      checkEq("s2_no_latch",   latch,      0);
    end
    applyStimulus(1'b1, 1'b1);
    tick();
    checkEq("s2_latch_after_done", latch,    1);
    checkEq("s2_req_dropped",      load_req, 0);

    $display("[TB] Scenario 3: enable dropped during blank of layer 5");
    n = 0;
    while (!(mLayer == 5 && mPos == 1) && n < 100) begin tick(); n++; end
    checkEq("s3_reach_l5_blank", n < 100, 1);
    applyStimulus(1'b0, 1'b1);
    lit = 0;
    n   = 0;
    while (mPos != -1 && n < 20) begin
      tick();
      if (layer_out == 8'h20) lit++;
      n++;
    end
    checkEq("s3_lit_cycles",  lit,        4);
    checkEq("s3_idle_busy",   busy,       0);
    checkEq("s3_kept_index",  load_layer, 6);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    checkEq("s3_resume_req",   load_req,   1);
    checkEq("s3_resume_layer", load_layer, 6);

    $display("[TB] Scenario 4: reset mid-hold of layer 7");
    n = 0;
    while (!(mLayer == 7 && mPos == B + 2) && n < 100) begin tick(); n++; end
    checkEq("s4_reach_l7_hold", n < 100, 1);
    rst_n = 1'b0;
    tick();
    checkEq("s4_rst_busy",      busy,       0);
    checkEq("s4_rst_layer_out", layer_out,  0);
    checkEq("s4_rst_index",     load_layer, 0);
    checkEq("s4_rst_frame",     frame_done, 0);
    rst_n = 1'b1;
    tick();
    checkEq("s4_restart_req",   load_req,   1);
    checkEq("s4_restart_layer", load_layer, 0);
    checkEq("s4_no_frame",      frame_done, 0);

    $display("[TB] Scenario 5: frame wrap");
    n = 0;
    while (!(mLayer == 7 && mPos == B + H) && n < 100) begin tick(); n++; end
    checkEq("s5_reach_l7_end", n < 100, 1);
    tick();
    checkEq("s5_frame_done", frame_done, 1);
    checkEq("s5_wrap_req",   load_req,   1);
    checkEq("s5_wrap_layer", load_layer, 0);

    $display("[TB] Scenario 6: random enable/load_done");
    for (int t = 0; t < 600; t++) begin
      applyStimulus($urandom_range(0, 9) != 0, ($urandom % 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
